ioctl_download_sender: RTL and testbench
========================================

Name: ioctl_download_sender

Overview:
- Drives the ioctl download interface that a core receives: ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout and ioctl_index, honouring ioctl_wait.
- Takes a byte stream over a valid/ready handshake, plus a start command carrying the index, base address and byte count.
- Used in the verilator benches to replay ROM and cassette images into the core without the HPS model.
- Also reusable as an on-chip loader.

Parameters:
- ADDR_W, 25, width of ioctl_addr, start_addr and length.
- PRE_CYCLES, 4, cycles ioctl_download is high before the first byte is requested. Range ≥1.
- WR_GAP, 1, idle cycles after each ioctl_wr pulse before the next byte is requested. Range ≥0.
- POST_CYCLES, 4, cycles ioctl_download stays high after the last ioctl_wr. Range ≥1.

Ports:
- clk_sys  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command; ignored while busy=1
- index  in  8  latched to ioctl_index on an accepted start
- start_addr  in  ADDR_W  address of the first byte
- length  in  ADDR_W  number of bytes to send; 0 is allowed
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  stream byte accepted when s_valid&&s_ready
- ioctl_download  out  1  transfer window
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_W  byte address
- ioctl_dout  out  8  byte data
- ioctl_index  out  8  file index
- ioctl_wait  in  1  receiver stall request
- busy  out  1  high from the cycle after an accepted start through the cycle ioctl_download falls
- done  out  1  one-cycle pulse in the cycle ioctl_download falls

Behaviour:
- Reset: all outputs go to 0 on the next clk_sys edge, in every state. FSM returns to IDLE and counters clear. If reset arrives mid-transfer, ioctl_download drops with no done pulse.
- FSM states: IDLE, PRE, REQ, WRITE, GAP, POST.
- IDLE:
  - On start: latch index, start_addr and length into registers; load the remaining-byte counter.
  - Next cycle: PRE, with ioctl_download=1, busy=1, ioctl_index=index, ioctl_addr=start_addr.
- PRE: lasts exactly PRE_CYCLES cycles, then goes to REQ if remaining≠0, else to POST.
- REQ:
  - s_ready = !ioctl_wait. s_ready is combinational and is 0 in every other state.
  - On s_valid&&s_ready: capture s_data and go to WRITE.
  - While ioctl_wait=1, REQ holds indefinitely.
- WRITE: one cycle.
  - ioctl_wr=1, ioctl_dout = the captured byte, ioctl_addr = the current address.
  - Then go to GAP if WR_GAP>0. If WR_GAP=0, go to REQ or POST directly.
- GAP: WR_GAP cycles, ioctl_wr=0.
- After WRITE/GAP: go to POST if remaining=0, else REQ.
- Address and counter update: ioctl_addr increments by 1 and remaining decrements by 1 in the cycle after WRITE.
- Address wrap-around: modulo 2^ADDR_W, no error.
- Output holding: ioctl_dout holds its value until the next WRITE. ioctl_addr holds its last incremented value after the transfer and is reloaded on the next start.
- POST: POST_CYCLES cycles, then IDLE. On the exit edge: ioctl_download=0, busy=0, done=1 for one cycle. ioctl_index holds.
- ioctl_wait rule: no ioctl_wr is ever issued unless a byte was accepted in a cycle with ioctl_wait=0. If ioctl_wait rises during WRITE, GAP or POST, the current strobe completes, and the next REQ stalls.
- start during busy: ignored, with no side effect.
- start in the same cycle as done: accepted; PRE begins the next cycle.
- s_valid while not in REQ: the byte is not consumed (s_ready=0).
- Max throughput: one byte per 2+WR_GAP cycles.

Test Plan:
- Basic timing: PRE=2, GAP=1, POST=2, start at cycle 0 (index=8'h01, start_addr=0, length=3), s_valid=1 with bytes AA,BB,CC, ioctl_wait=0.
  - Expect ioctl_download high cycles 1–12.
  - Expect ioctl_wr at cycles 4/7/10 with addr 0/1/2 and dout AA/BB/CC.
  - Expect done at 13 and ioctl_index=01.
- Stall: same setup, ioctl_wait=1 cycles 5–20 → second s_ready not before 21, second ioctl_wr at cycle 22 with addr=1; total exactly 3 ioctl_wr pulses.
- Source starvation: s_valid low 10 cycles mid-stream → FSM holds REQ, no ioctl_wr, addresses contiguous afterwards.
- length=0, PRE=2, POST=2: ioctl_download high cycles 1–4, zero ioctl_wr, s_ready never 1, done at 5.
- Wrap and back-to-back: start_addr=25'h1FFFFFF, length=2 → ioctl_wr addr 1FFFFFF then 0000000. start in the done cycle is accepted; a start pulse while busy is ignored, checked by pulse count.
- Reset mid-transfer: reset asserted after the second ioctl_wr → next cycle all outputs 0, no done pulse. A new start then transfers correctly from start_addr.

Source files
------------

// File: rtl/ioctl_download_sender.sv
// ioctl_download_sender
//
// Replays a byte stream into a core through the ioctl download interface.
// A start command latches the file index, base address and byte count. The
// sender then raises ioctl_download, waits PRE_CYCLES, and pulls bytes one at
// a time from a valid/ready stream. It issues one ioctl_wr strobe per byte at
// consecutive addresses, keeps the window open for POST_CYCLES after the last
// strobe, and signals completion with a one-cycle done pulse.
//
// Ports
//   clk_sys, reset        single clock, synchronous active-high reset
//   start                 one-cycle command, ignored while busy
//   index                 file index, latched on an accepted start
//   start_addr            address of the first byte
//   length                number of bytes to send (0 allowed)
//   s_data/s_valid/s_ready  byte stream, transfer on s_valid && s_ready
//   ioctl_download        transfer window
//   ioctl_wr              one-cycle write strobe
//   ioctl_addr            byte address
//   ioctl_dout            byte data
//   ioctl_index           file index
//   ioctl_wait            receiver stall request
//   busy                  transfer in progress
//   done                  one-cycle pulse in the cycle ioctl_download falls
module ioctl_download_sender #(
    parameter int ADDR_W      = 25,
    parameter int PRE_CYCLES  = 4,
    parameter int WR_GAP      = 1,
    parameter int POST_CYCLES = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_REQ,
        S_WRITE,
        S_GAP,
        S_POST
    } state_t;

    localparam logic [15:0] PRE_LAST  = 16'(PRE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'((WR_GAP > 0) ? (WR_GAP - 1) : 0);
    localparam logic [15:0] POST_LAST = 16'(POST_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        index_q, index_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            dout_q  <= '0;
            index_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            index_q <= index_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        index_d = index_q;
        done_d  = 1'b0;
        s_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = index;
                    addr_d  = start_addr;
                    rem_d   = length;
                    cnt_d   = '0;
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    state_d = (rem_q != '0) ? S_REQ : S_POST;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_REQ: begin
                // Bytes are only accepted while the receiver is not stalling,
                // so every strobe corresponds to a byte taken with wait low.
                s_ready = !ioctl_wait;
                if (s_valid && !ioctl_wait) begin
                    dout_d  = s_data;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - ADDR_W'(1);
                cnt_d  = '0;
                // The gap only paces the next request; after the final byte the
                // POST window starts right away so it counts from the last strobe.
                if (rem_q == ADDR_W'(1)) begin
                    state_d = S_POST;
                end else if (WR_GAP > 0) begin
                    state_d = S_GAP;
                end else begin
                    state_d = S_REQ;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_POST: begin
                if (cnt_q == POST_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign ioctl_download = (state_q != S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign ioctl_wr       = (state_q == S_WRITE);
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
    assign ioctl_index    = index_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ioctl_download_sender.sv
module tb_ioctl_download_sender;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  index;
    logic [24:0] start_addr;
    logic [24:0] length;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        busy;
    logic        done;

    ioctl_download_sender #(
        .ADDR_W(25), .PRE_CYCLES(2), .WR_GAP(1), .POST_CYCLES(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .start(start), .index(index),
        .start_addr(start_addr), .length(length), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_index(ioctl_index), .ioctl_wait(ioctl_wait), .busy(busy),
        .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Event log gathered on the falling edge.
    int          wr_cyc[$];
    logic [24:0] wr_addr[$];
    logic [7:0]  wr_dout[$];
    int          done_cyc[$];
    int          rdy_cyc[$];

    always @(negedge clk_sys) begin
        if (ioctl_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(ioctl_addr);
            wr_dout.push_back(ioctl_dout);
        end
        if (done) done_cyc.push_back(cyc);
        if (s_ready) rdy_cyc.push_back(cyc);
    end

    int passed = 0;
    int total  = 0;
    int t0     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_wr(input string nm, input int i, input int rel,
                          input logic [24:0] a, input logic [7:0] d);
        if (i < wr_cyc.size()) begin
            chk(nm, {16'(wr_cyc[i] - t0), wr_addr[i], wr_dout[i]}, {16'(rel), a, d});
        end else begin
            total++;
            $display("FAIL %s: write %0d missing, got %0d writes", nm, i, wr_cyc.size());
        end
    endtask

    task automatic chk_done_at(input string nm, input int rel);
        if (done_cyc.size() > 0) chk(nm, done_cyc[0] - t0, rel);
        else begin
            total++;
            $display("FAIL %s: no done pulse, expected at rel %0d", nm, rel);
        end
    endtask

    task automatic clear_log();
        wr_cyc.delete(); wr_addr.delete(); wr_dout.delete();
        done_cyc.delete(); rdy_cyc.delete();
    endtask

    function automatic logic [45:0] ov(input logic dl, input logic wr, input logic [24:0] a,
                                       input logic [7:0] d, input logic dn, input logic rdy,
                                       input logic bz, input logic [7:0] ix);
        return {dl, wr, a, d, dn, rdy, bz, ix};
    endfunction

    function automatic logic [45:0] outs();
        return {ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, done, s_ready, busy, ioctl_index};
    endfunction

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic        st;
        logic [7:0]  ix;
        logic [24:0] sa;
        logic [24:0] len;
        logic        sv;
        logic [7:0]  sd;
        logic [45:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  tidx;
    logic [24:0] tsa, tlen;

    task automatic add(input logic st, input logic sv, input logic [7:0] sd, input logic [45:0] e);
        vec_t v;
        v.st = st; v.ix = tidx; v.sa = tsa; v.len = tlen; v.sv = sv; v.sd = sd; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string nm);
        foreach (tbl[i]) begin
            start = tbl[i].st; index = tbl[i].ix; start_addr = tbl[i].sa;
            length = tbl[i].len; s_valid = tbl[i].sv; s_data = tbl[i].sd;
            ioctl_wait = 1'b0;
            @(negedge clk_sys);
            chk($sformatf("%s[%0d]", nm, i), outs(), tbl[i].exp);
            @(posedge clk_sys); #1;
        end
        start = 1'b0; s_valid = 1'b0;
        tbl.delete();
    endtask

    // ---------------- stream-driven cycle step ----------------
    logic [7:0] bq[$];

    task automatic step(input logic st, input logic w, input logic sv_en, input logic rs);
        logic fire;
        start = st; ioctl_wait = w; reset = rs;
        s_valid = sv_en && (bq.size() > 0);
        s_data  = (bq.size() > 0) ? bq[0] : 8'h00;
        @(negedge clk_sys);
        fire = s_valid && s_ready;
        @(posedge clk_sys); #1;
        if (fire) void'(bq.pop_front());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; index = 8'h00; start_addr = '0; length = '0;
        s_data = 8'h00; s_valid = 1'b0; ioctl_wait = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        chk("reset_state", outs(), 46'd0);

        // Basic timing: index 01, addr 0, three bytes.
        tidx = 8'h01; tsa = 25'h0; tlen = 25'd3;
        add(1, 1, 8'hAA, ov(0, 0, 25'h0, 8'h00, 0, 0, 0, 8'h00));
        add(0, 1, 8'hAA, ov(1, 0, 25'h0, 8'h00, 0, 0, 1, 8'h01));
        add(0, 1, 8'hAA, ov(1, 0, 25'h0, 8'h00, 0, 0, 1, 8'h01));
        add(0, 1, 8'hAA, ov(1, 0, 25'h0, 8'h00, 0, 1, 1, 8'h01));
        add(0, 1, 8'hBB, ov(1, 1, 25'h0, 8'hAA, 0, 0, 1, 8'h01));
        add(0, 1, 8'hBB, ov(1, 0, 25'h1, 8'hAA, 0, 0, 1, 8'h01));
        add(0, 1, 8'hBB, ov(1, 0, 25'h1, 8'hAA, 0, 1, 1, 8'h01));
        add(0, 1, 8'hCC, ov(1, 1, 25'h1, 8'hBB, 0, 0, 1, 8'h01));
        add(0, 1, 8'hCC, ov(1, 0, 25'h2, 8'hBB, 0, 0, 1, 8'h01));
        add(0, 1, 8'hCC, ov(1, 0, 25'h2, 8'hBB, 0, 1, 1, 8'h01));
        add(0, 1, 8'h00, ov(1, 1, 25'h2, 8'hCC, 0, 0, 1, 8'h01));
        add(0, 1, 8'h00, ov(1, 0, 25'h3, 8'hCC, 0, 0, 1, 8'h01));
        add(0, 1, 8'h00, ov(1, 0, 25'h3, 8'hCC, 0, 0, 1, 8'h01));
        add(0, 1, 8'h00, ov(0, 0, 25'h3, 8'hCC, 1, 0, 0, 8'h01));
        run_table("basic");

        // Zero-length transfer: window only, no strobes, no ready.
        tidx = 8'h02; tsa = 25'h10; tlen = 25'd0;
        add(1, 1, 8'hEE, ov(0, 0, 25'h3,  8'hCC, 0, 0, 0, 8'h01));
        add(0, 1, 8'hEE, ov(1, 0, 25'h10, 8'hCC, 0, 0, 1, 8'h02));
        add(0, 1, 8'hEE, ov(1, 0, 25'h10, 8'hCC, 0, 0, 1, 8'h02));
        add(0, 1, 8'hEE, ov(1, 0, 25'h10, 8'hCC, 0, 0, 1, 8'h02));
        add(0, 1, 8'hEE, ov(1, 0, 25'h10, 8'hCC, 0, 0, 1, 8'h02));
        add(0, 1, 8'hEE, ov(0, 0, 25'h10, 8'hCC, 1, 0, 0, 8'h02));
        add(0, 1, 8'hEE, ov(0, 0, 25'h10, 8'hCC, 0, 0, 0, 8'h02));
        run_table("len0");

        // Stall: ioctl_wait high during relative cycles 5..20.
        repeat (2) step(0, 0, 0, 0);
        clear_log();
        index = 8'h01; start_addr = 25'h0; length = 25'd3;
        bq = '{8'hAA, 8'hBB, 8'hCC};
        t0 = cyc;
        for (int r = 0; r < 31; r++) step(r == 0, (r >= 5 && r <= 20), 1'b1, 1'b0);
        chk("stall_wr_count", wr_cyc.size(), 3);
        chk_wr("stall_wr0", 0, 4,  25'h0, 8'hAA);
        chk_wr("stall_wr1", 1, 22, 25'h1, 8'hBB);
        chk_wr("stall_wr2", 2, 25, 25'h2, 8'hCC);
        n = 0;
        foreach (rdy_cyc[i]) if (rdy_cyc[i] - t0 >= 5 && rdy_cyc[i] - t0 <= 20) n++;
        chk("stall_no_ready", n, 0);
        chk_done_at("stall_done", 28);

        // Source starvation: s_valid low during relative cycles 6..15.
        repeat (2) step(0, 0, 0, 0);
        clear_log();
        index = 8'h07; start_addr = 25'h100; length = 25'd4;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        t0 = cyc;
        for (int r = 0; r < 31; r++) step(r == 0, 1'b0, !(r >= 6 && r <= 15), 1'b0);
        chk("starve_wr_count", wr_cyc.size(), 4);
        chk_wr("starve_wr0", 0, 4,  25'h100, 8'h11);
        chk_wr("starve_wr1", 1, 17, 25'h101, 8'h22);
        chk_wr("starve_wr2", 2, 20, 25'h102, 8'h33);
        chk_wr("starve_wr3", 3, 23, 25'h103, 8'h44);
        chk_done_at("starve_done", 26);

        // Address wrap, start while busy (ignored), start in the done cycle.
        repeat (2) step(0, 0, 0, 0);
        clear_log();
        bq = '{8'h5A, 8'hA5, 8'h77};
        t0 = cyc;
        for (int r = 0; r < 23; r++) begin
            if (r == 0)  begin index = 8'h03; start_addr = 25'h1FFFFFF; length = 25'd2; end
            if (r == 3)  begin index = 8'h09; start_addr = 25'h555;     length = 25'd5; end
            if (r == 10) begin index = 8'h04; start_addr = 25'h40;      length = 25'd1; end
            step(r == 0 || r == 3 || r == 10, 1'b0, 1'b1, 1'b0);
        end
        chk("wrap_wr_count", wr_cyc.size(), 3);
        chk_wr("wrap_wr0", 0, 4,  25'h1FFFFFF, 8'h5A);
        chk_wr("wrap_wr1", 1, 7,  25'h0,       8'hA5);
        chk_wr("wrap_wr2", 2, 14, 25'h40,      8'h77);
        chk("wrap_done_count", done_cyc.size(), 2);
        chk_done_at("wrap_done0", 10);
        if (done_cyc.size() > 1) chk("wrap_done1", done_cyc[1] - t0, 17);
        chk("wrap_index_addr", {ioctl_index, ioctl_addr}, {8'h04, 25'h41});

        // Reset after the second strobe, then a clean restart.
        repeat (2) step(0, 0, 0, 0);
        clear_log();
        index = 8'h05; start_addr = 25'h200; length = 25'd4;
        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        t0 = cyc;
        for (int r = 0; r < 9; r++) step(r == 0, 1'b0, 1'b1, r == 8);
        chk("rst_outputs_zero", outs(), 46'd0);
        bq.delete();
        for (int r = 0; r < 4; r++) step(0, 0, 0, 0);
        chk("rst_pre_wr_count", wr_cyc.size(), 2);
        chk("rst_no_done", done_cyc.size(), 0);
        clear_log();
        index = 8'h06; start_addr = 25'h300; length = 25'd2;
        bq = '{8'h0A, 8'h0B};
        t0 = cyc;
        for (int r = 0; r < 13; r++) step(r == 0, 1'b0, 1'b1, 1'b0);
        chk("rst_new_wr_count", wr_cyc.size(), 2);
        chk_wr("rst_new_wr0", 0, 4, 25'h300, 8'h0A);
        chk_wr("rst_new_wr1", 1, 7, 25'h301, 8'h0B);
        chk_done_at("rst_new_done", 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
